// File: rtl/hazard3_dbg_reset_ctrl_pkg.sv
// Shared definitions for the debug reset sequencer.
// Contents:
//   rst_state_e : channel FSM states. The encoding is fixed (0/1/2) so that
//                 waveforms and any external decode stay stable.
//   cnt_width() : width of a counter that must hold the value 0..cycles.
package hazard3_dbg_reset_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_ASSERT   = 2'd0,
    ST_WAIT_ACK = 2'd1,
    ST_RUN      = 2'd2
  } rst_state_e;

  function automatic int cnt_width(input int cycles);
    return (cycles < 1) ? 1 : $clog2(cycles + 1);
  endfunction

endpackage

// File: rtl/hazard3_reset_seq.sv
// One reset channel: ack synchroniser, minimum-width counter and the
// ASSERT -> WAIT_ACK -> RUN sequencer with registered outputs.
// Ports:
//   clk, rst_n : clock and asynchronous active-low reset
//   req_i      : level reset request (any cycle high restarts the pulse)
//   ack_i      : asynchronous downstream release indication (high = released)
//   rst_n_o    : registered active-low reset to downstream logic
//   done_o     : registered "sequence complete"
module hazard3_reset_seq
  import hazard3_dbg_reset_ctrl_pkg::*;
#(
  parameter int ASSERT_CYCLES = 8,
  parameter int SYNC_STAGES   = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic req_i,
  input  logic ack_i,
  output logic rst_n_o,
  output logic done_o
);

  localparam int                CNT_W   = cnt_width(ASSERT_CYCLES);
  localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(ASSERT_CYCLES);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   ack_s;
  rst_state_e             state_q, state_d;
  logic [CNT_W-1:0]       count_q, count_d;
  logic                   out_q, out_d;
  logic                   done_q, done_d;

  // Plain flop chain bringing the asynchronous ack into clk. It clears to 0
  // so that a reset of this block never looks like a downstream release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], ack_i};
    end
  end

  assign ack_s = sync_q[SYNC_STAGES-1];

  // State, counter and the two output flops. The outputs are registered
  // copies of the decoded next state so they change only on clock edges.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_ASSERT;
      count_q <= '0;
      out_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      out_q   <= out_d;
      done_q  <= done_d;
    end
  end

  // Next-state logic. Leaving ASSERT needs the full count, no request and a
  // low synchronised ack: the ack must be seen low so we know the downstream
  // reset really took effect, and a stuck-high ack deliberately holds us in
  // ASSERT. A request in any other state restarts the pulse from count 0.
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    case (state_q)
      ST_ASSERT: begin
        if (count_q != CNT_MAX) begin
          count_d = count_q + CNT_W'(1);
        end
        if ((count_q == CNT_MAX) && !req_i && !ack_s) begin
          state_d = ST_WAIT_ACK;
        end
      end
      ST_WAIT_ACK: begin
        if (req_i) begin
          state_d = ST_ASSERT;
          count_d = '0;
        end else if (ack_s) begin
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        if (req_i) begin
          state_d = ST_ASSERT;
          count_d = '0;
        end
      end
      default: begin
        state_d = ST_ASSERT;
        count_d = '0;
      end
    endcase
    out_d  = (state_d != ST_ASSERT);
    done_d = (state_d == ST_RUN);
  end

  assign rst_n_o = out_q;
  assign done_o  = done_q;

endmodule

// File: rtl/hazard3_dbg_reset_ctrl.sv
// Debug reset sequencer between the Debug Module reset requests and the
// system / per-hart reset synchronisers.
// Ports:
//   clk, rst_n          : clock and asynchronous active-low reset
//   sys_reset_req       : DM system reset request (level)
//   sys_reset_done      : system and all harts have completed their sequence
//   hart_reset_req      : DM per-hart reset requests (level)
//   hart_reset_done     : per-hart sequence complete
//   rst_n_sys_out       : registered active-low reset to non-hart logic
//   sys_rst_ack         : downstream system reset released (asynchronous)
//   rst_n_hart_out      : registered active-low reset to each hart
//   hart_rst_ack        : each hart's synchronised rst_n (asynchronous)
module hazard3_dbg_reset_ctrl
  import hazard3_dbg_reset_ctrl_pkg::*;
#(
  parameter int N_HARTS       = 1,
  parameter int ASSERT_CYCLES = 8,
  parameter int SYNC_STAGES   = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               sys_reset_req,
  output logic               sys_reset_done,
  input  logic [N_HARTS-1:0] hart_reset_req,
  output logic [N_HARTS-1:0] hart_reset_done,
  output logic               rst_n_sys_out,
  input  logic               sys_rst_ack,
  output logic [N_HARTS-1:0] rst_n_hart_out,
  input  logic [N_HARTS-1:0] hart_rst_ack
);

  logic sys_done;
  logic sys_in_assert;
  logic sys_reset_done_q, sys_reset_done_d;

  hazard3_reset_seq #(
    .ASSERT_CYCLES (ASSERT_CYCLES),
    .SYNC_STAGES   (SYNC_STAGES)
  ) u_sys_seq (
    .clk     (clk),
    .rst_n   (rst_n),
    .req_i   (sys_reset_req),
    .ack_i   (sys_rst_ack),
    .rst_n_o (rst_n_sys_out),
    .done_o  (sys_done)
  );

  // The system channel output is a flop that is low exactly while that
  // channel sits in ASSERT, so its inverse is a registered "in ASSERT" flag.
  // Feeding it into every hart request makes the harts follow a system reset
  // one cycle later and hold until the system channel lets go.
  assign sys_in_assert = ~rst_n_sys_out;

  for (genvar i = 0; i < N_HARTS; i++) begin : g_hart
    hazard3_reset_seq #(
      .ASSERT_CYCLES (ASSERT_CYCLES),
      .SYNC_STAGES   (SYNC_STAGES)
    ) u_hart_seq (
      .clk     (clk),
      .rst_n   (rst_n),
      .req_i   (hart_reset_req[i] | sys_in_assert),
      .ack_i   (hart_rst_ack[i]),
      .rst_n_o (rst_n_hart_out[i]),
      .done_o  (hart_reset_done[i])
    );
  end

  // System done waits for every hart as well; registering it keeps the
  // output glitch-free at the cost of one cycle of latency.
  assign sys_reset_done_d = sys_done & (&hart_reset_done);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sys_reset_done_q <= 1'b0;
    end else begin
      sys_reset_done_q <= sys_reset_done_d;
    end
  end

  assign sys_reset_done = sys_reset_done_q;

endmodule

// File: tb/tb_hazard3_dbg_reset_ctrl.sv
// Self-checking bench for hazard3_dbg_reset_ctrl with two harts. The
// downstream synchronisers are modelled as a 3-flop delay from each rst_n
// output back to its ack input; staleHi can pin hart 0's ack high.
module tb_hazard3_dbg_reset_ctrl;

  localparam int NH = 2;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          sys_reset_req = 1'b0;
  logic          sys_reset_done;
  logic [NH-1:0] hart_reset_req = '0;
  logic [NH-1:0] hart_reset_done;
  logic          rst_n_sys_out;
  logic          sys_rst_ack;
  logic [NH-1:0] rst_n_hart_out;
  logic [NH-1:0] hart_rst_ack;

  logic [2:0] sysPipe = '0;
  logic [2:0] hart0Pipe = '0;
  logic [2:0] hart1Pipe = '0;
  logic       staleHi = 1'b0;

  int compared = 0;
  int mismatched = 0;

  hazard3_dbg_reset_ctrl #(
    .N_HARTS       (NH),
    .ASSERT_CYCLES (8),
    .SYNC_STAGES   (2)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .sys_reset_req   (sys_reset_req),
    .sys_reset_done  (sys_reset_done),
    .hart_reset_req  (hart_reset_req),
    .hart_reset_done (hart_reset_done),
    .rst_n_sys_out   (rst_n_sys_out),
    .sys_rst_ack     (sys_rst_ack),
    .rst_n_hart_out  (rst_n_hart_out),
    .hart_rst_ack    (hart_rst_ack)
  );

  // Free-running 10-unit clock.
  always #5 clk = ~clk;

  // Downstream reset synchroniser model: each ack follows its rst_n output
  // three clocks later.
  always @(posedge clk) begin
    sysPipe   <= {sysPipe[1:0], rst_n_sys_out};
    hart0Pipe <= {hart0Pipe[1:0], rst_n_hart_out[0]};
    hart1Pipe <= {hart1Pipe[1:0], rst_n_hart_out[1]};
  end

  assign sys_rst_ack  = sysPipe[2];
  assign hart_rst_ack = {hart1Pipe[2], hart0Pipe[2] | staleHi};

  // Records, relative to a reset release, the first sample (after clock
  // edge c) at which each output is high, plus rst_n_sys_out at c=8.
  task automatic measure_release(output int sysHi, output int hartHi,
                                 output int hartDoneHi, output int sysDoneHi,
                                 output int sysAt8);
    sysHi = -1; hartHi = -1; hartDoneHi = -1; sysDoneHi = -1; sysAt8 = -1;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      if (sysHi < 0 && rst_n_sys_out === 1'b1) sysHi = c;
      if (hartHi < 0 && rst_n_hart_out === 2'b11) hartHi = c;
      if (hartDoneHi < 0 && hart_reset_done === 2'b11) hartDoneHi = c;
      if (sysDoneHi < 0 && sys_reset_done === 1'b1) sysDoneHi = c;
      if (c == 8) sysAt8 = int'(rst_n_sys_out);
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    compared++;
    if (rst_n_sys_out !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL reset_sys_out: got %b expected 0", rst_n_sys_out);
    end
    compared++;
    if (rst_n_hart_out !== 2'b00) begin
      mismatched++;
      $display("[TB] FAIL reset_hart_out: got %b expected 00", rst_n_hart_out);
    end
    compared++;
    if (hart_reset_done !== 2'b00) begin
      mismatched++;
      $display("[TB] FAIL reset_hart_done: got %b expected 00", hart_reset_done);
    end
    compared++;
    if (sys_reset_done !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL reset_sys_done: got %b expected 0", sys_reset_done);
    end
  endtask

  // Release timings after power-on (also reused after a mid-sequence reset):
  // system out at 9, harts one later at 10, hart done at 16, system done 17.
  task automatic test_power_on(input string tag);
    int sysHi, hartHi, hartDoneHi, sysDoneHi, sysAt8;
    @(negedge clk);
    rst_n = 1'b1;
    measure_release(sysHi, hartHi, hartDoneHi, sysDoneHi, sysAt8);
    compared++;
    if (sysAt8 !== 0) begin
      mismatched++;
      $display("[TB] FAIL %s_sys_low_at8: got %0d expected 0", tag, sysAt8);
    end
    compared++;
    if (sysHi !== 9) begin
      mismatched++;
      $display("[TB] FAIL %s_sys_release: got %0d expected 9", tag, sysHi);
    end
    compared++;
    if (hartHi !== 10) begin
      mismatched++;
      $display("[TB] FAIL %s_hart_release: got %0d expected 10", tag, hartHi);
    end
    compared++;
    if (hartDoneHi !== 16) begin
      mismatched++;
      $display("[TB] FAIL %s_hart_done: got %0d expected 16", tag, hartDoneHi);
    end
    compared++;
    if (sysDoneHi !== 17) begin
      mismatched++;
      $display("[TB] FAIL %s_sys_done: got %0d expected 17", tag, sysDoneHi);
    end
  endtask

  task automatic test_hart_pulse();
    int outLow = 0, doneLow = 0, sysLow = 0, hart1Low = 0, sysDoneLow = 0;
    @(negedge clk);
    hart_reset_req = 2'b01;
    for (int c = 0; c < 25; c++) begin
      @(negedge clk);
      if (rst_n_hart_out[0] === 1'b0) outLow++;
      if (hart_reset_done[0] === 1'b0) doneLow++;
      if (rst_n_sys_out === 1'b0) sysLow++;
      if (rst_n_hart_out[1] === 1'b0) hart1Low++;
      if (sys_reset_done === 1'b0) sysDoneLow++;
      if (c == 0) hart_reset_req = 2'b00;
    end
    compared++;
    if (outLow !== 9) begin
      mismatched++;
      $display("[TB] FAIL pulse_hart0_low_width: got %0d expected 9", outLow);
    end
    compared++;
    if (doneLow !== 15) begin
      mismatched++;
      $display("[TB] FAIL pulse_hart0_done_low: got %0d expected 15", doneLow);
    end
    compared++;
    if (sysLow !== 0) begin
      mismatched++;
      $display("[TB] FAIL pulse_sys_out_low: got %0d expected 0", sysLow);
    end
    compared++;
    if (hart1Low !== 0) begin
      mismatched++;
      $display("[TB] FAIL pulse_hart1_low: got %0d expected 0", hart1Low);
    end
    compared++;
    if (sysDoneLow !== 15) begin
      mismatched++;
      $display("[TB] FAIL pulse_sys_done_low: got %0d expected 15", sysDoneLow);
    end
  endtask

  task automatic test_sys_hold();
    int sysLow = 0, sysFirstLow = -1, hartLow = 0, hartFirstLow = -1;
    int hartDoneHi = -1, sysDoneHi = -1;
    @(negedge clk);
    sys_reset_req = 1'b1;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (rst_n_sys_out === 1'b0) begin
        sysLow++;
        if (sysFirstLow < 0) sysFirstLow = c;
      end
      if (rst_n_hart_out === 2'b00) begin
        hartLow++;
        if (hartFirstLow < 0) hartFirstLow = c;
      end
      if (c >= 2 && hartDoneHi < 0 && hart_reset_done === 2'b11) hartDoneHi = c;
      if (c >= 2 && sysDoneHi < 0 && sys_reset_done === 1'b1) sysDoneHi = c;
      if (c == 19) sys_reset_req = 1'b0;
    end
    compared++;
    if (sysLow !== 20) begin
      mismatched++;
      $display("[TB] FAIL hold_sys_low_width: got %0d expected 20", sysLow);
    end
    compared++;
    if (sysFirstLow !== 0) begin
      mismatched++;
      $display("[TB] FAIL hold_sys_first_low: got %0d expected 0", sysFirstLow);
    end
    compared++;
    if (hartLow !== 20) begin
      mismatched++;
      $display("[TB] FAIL hold_hart_low_width: got %0d expected 20", hartLow);
    end
    compared++;
    if (hartFirstLow !== 1) begin
      mismatched++;
      $display("[TB] FAIL hold_hart_first_low: got %0d expected 1", hartFirstLow);
    end
    compared++;
    if (hartDoneHi !== 27) begin
      mismatched++;
      $display("[TB] FAIL hold_hart_done: got %0d expected 27", hartDoneHi);
    end
    compared++;
    if (sysDoneHi !== 28) begin
      mismatched++;
      $display("[TB] FAIL hold_sys_done: got %0d expected 28", sysDoneHi);
    end
  endtask

  task automatic test_stale_ack();
    int outHi = -1, doneHi = -1;
    @(negedge clk);
    staleHi = 1'b1;
    hart_reset_req = 2'b01;
    @(negedge clk);
    hart_reset_req = 2'b00;
    repeat (29) @(negedge clk);
    compared++;
    if (rst_n_hart_out[0] !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL stale_out_held: got %b expected 0", rst_n_hart_out[0]);
    end
    compared++;
    if (hart_reset_done[0] !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL stale_done_held: got %b expected 0", hart_reset_done[0]);
    end
    staleHi = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (outHi < 0 && rst_n_hart_out[0] === 1'b1) outHi = c;
      if (doneHi < 0 && hart_reset_done[0] === 1'b1) doneHi = c;
    end
    compared++;
    if (outHi !== 2) begin
      mismatched++;
      $display("[TB] FAIL stale_release: got %0d expected 2", outHi);
    end
    compared++;
    if (doneHi !== 8) begin
      mismatched++;
      $display("[TB] FAIL stale_done: got %0d expected 8", doneHi);
    end
  endtask

  task automatic test_reassert_wait_ack();
    logic outHist [40];
    int   lowCount = 0, doneHi = -1;
    @(negedge clk);
    hart_reset_req = 2'b01;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      outHist[c] = rst_n_hart_out[0];
      if (rst_n_hart_out[0] === 1'b0) lowCount++;
      if (doneHi < 0 && hart_reset_done[0] === 1'b1) doneHi = c;
      if (c == 0)  hart_reset_req = 2'b00;
      if (c == 10) hart_reset_req = 2'b01;
      if (c == 11) hart_reset_req = 2'b00;
    end
    compared++;
    if (outHist[10] !== 1'b1) begin
      mismatched++;
      $display("[TB] FAIL reassert_in_wait_ack: got %b expected 1", outHist[10]);
    end
    compared++;
    if (outHist[11] !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL reassert_drop: got %b expected 0", outHist[11]);
    end
    compared++;
    if (outHist[19] !== 1'b0 || outHist[20] !== 1'b1) begin
      mismatched++;
      $display("[TB] FAIL reassert_second_width: got %b%b expected 01",
               outHist[19], outHist[20]);
    end
    compared++;
    if (lowCount !== 18) begin
      mismatched++;
      $display("[TB] FAIL reassert_total_low: got %0d expected 18", lowCount);
    end
    compared++;
    if (doneHi !== 26) begin
      mismatched++;
      $display("[TB] FAIL reassert_done: got %0d expected 26", doneHi);
    end
  endtask

  task automatic test_rst_mid_sequence();
    @(negedge clk);
    sys_reset_req = 1'b1;
    for (int c = 0; c <= 4; c++) begin
      @(negedge clk);
      if (c == 0) sys_reset_req = 1'b0;
    end
    rst_n = 1'b0;
    #1;
    compared++;
    if ({rst_n_sys_out, rst_n_hart_out, hart_reset_done, sys_reset_done} !== 6'b0) begin
      mismatched++;
      $display("[TB] FAIL midrst_outputs: got %b expected 000000",
               {rst_n_sys_out, rst_n_hart_out, hart_reset_done, sys_reset_done});
    end
    repeat (2) @(negedge clk);
    test_power_on("midrst");
  endtask

  initial begin
    $display("[TB] start");
    test_reset();
    test_power_on("poweron");
    repeat (5) @(negedge clk);
    test_hart_pulse();
    repeat (10) @(negedge clk);
    test_sys_hold();
    repeat (10) @(negedge clk);
    test_stale_ack();
    repeat (20) @(negedge clk);
    test_reassert_wait_ack();
    repeat (20) @(negedge clk);
    test_rst_mid_sequence();
    repeat (5) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
